// File: rtl/mem_stage_lsu.sv
// ============================================================================
// mem_stage_lsu
// ----------------------------------------------------------------------------
// Memory-access stage of the 5-stage RV32I pipeline. It sits between the
// EX/MEM and MEM/WB registers.
//
// Behaviour
//   - Takes the load/store from EX/MEM and drives it onto a data-memory port
//     that uses a ready handshake.
//   - Stalls the upstream pipeline until the access completes.
//   - Forwards writeback control to MEM/WB.
//   - Returns sign- or zero-extended load data.
//
// Access sequencing (FSM: IDLE -> REQ -> DONE -> IDLE)
//   IDLE  Latches the access and raises the stall.
//   REQ   Holds a stable request until dmem_ready. After WAIT_LIMIT cycles
//         without dmem_ready, the access times out.
//   DONE  Releases the stall for exactly one cycle, so the stalled
//         instruction retires.
//
// Parameters
//   WAIT_LIMIT   Maximum number of REQ cycles without dmem_ready before the
//                access is abandoned with a bus error (must be >= 1).
//
// Configuration macro
//   MEM_MISALIGN_TRAP_EN
//     Defined: a misaligned halfword or word access is not sent to memory.
//       It goes IDLE -> DONE and raises misalign_o for that DONE cycle.
//     Undefined: the address bits below the access size are ignored, and
//       misalign_o is tied low.
//
// Ports
//   clk, rst              Clock (rising edge). Reset is asynchronous and
//                         active-high.
//   rf_en_in .. pc_in     EX/MEM control and data.
//   dmem_*                Data-memory port. dmem_rdata is valid in the same
//                         cycle as dmem_ready.
//   stall_o               Freezes PC, IF/ID, ID/EX and EX/MEM, and inserts a
//                         bubble into MEM/WB.
//   rf_en_out             Regfile write enable, gated for bubbles and for
//                         faulted accesses.
//   wb_sel_out, rd_out,
//   alu_result_out,
//   pc_out                Combinational pass-through of the inputs.
//   load_data_out         Registered, extended load data. Valid in DONE.
//   bus_err_o             One-cycle pulse in DONE when the access timed out.
//   misalign_o            One-cycle pulse in DONE when a misaligned access
//                         was trapped.
// ============================================================================
module mem_stage_lsu #(
   parameter int WAIT_LIMIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rf_en_in,
   input  logic [1:0]  wb_sel_in,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic [2:0]  func3_in,
   input  logic [31:0] alu_result_in,
   input  logic [31:0] write_data_in,
   input  logic [4:0]  rd_in,
   input  logic [31:0] pc_in,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        stall_o,
   output logic        rf_en_out,
   output logic [1:0]  wb_sel_out,
   output logic [4:0]  rd_out,
   output logic [31:0] alu_result_out,
   output logic [31:0] pc_out,
   output logic [31:0] load_data_out,
   output logic        bus_err_o,
   output logic        misalign_o
);

   localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Access size taken from func3: 0 = byte, 1 = halfword, 2 = word.
   // The reserved encodings (011, 110, 111) are treated as word accesses.
   function automatic logic [1:0] access_size(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: access_size = 2'd0;
         3'b001, 3'b101: access_size = 2'd1;
         default:        access_size = 2'd2;
      endcase
   endfunction

   // Select the addressed lane of the read word, then extend it.
   // A halfword is selected by addr[1] only, so a halfword at an odd address
   // reads the aligned halfword that contains it.
   function automatic logic [31:0] extend_load(input logic [31:0] rdata,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
      logic [7:0]  lane_b;
      logic [15:0] lane_h;
      lane_b = rdata[{off, 3'b000} +: 8];
      lane_h = rdata[{off[1], 4'b0000} +: 16];
      case (f3)
         3'b000:  extend_load = {{24{lane_b[7]}}, lane_b};
         3'b001:  extend_load = {{16{lane_h[15]}}, lane_h};
         3'b100:  extend_load = {24'd0, lane_b};
         3'b101:  extend_load = {16'd0, lane_h};
         default: extend_load = rdata;
      endcase
   endfunction

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [31:0]       addr_q, addr_d;
   logic              we_q, we_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [2:0]        func3_q, func3_d;
   logic [1:0]        offset_q, offset_d;
   logic              is_load_q, is_load_d;
   logic [31:0]       load_data_q, load_data_d;
   logic              bus_err_q, bus_err_d;
   logic              misalign_q, misalign_d;

   logic              mem_op;
   logic [3:0]        st_be;
   logic [31:0]       st_wdata;
   logic              misaligned;

   assign mem_op = mem_read_in | mem_write_in;

   // Store lane steering, computed from the live EX/MEM inputs so it can be
   // latched on the IDLE -> REQ transition. The data is replicated across
   // every lane, so only the byte enables have to depend on the address.
   always_comb begin
      st_be    = 4'hF;
      st_wdata = write_data_in;
      case (access_size(func3_in))
         2'd0: begin
            st_be    = 4'b0001 << alu_result_in[1:0];
            st_wdata = {4{write_data_in[7:0]}};
         end
         2'd1: begin
            st_be    = 4'b0011 << {alu_result_in[1], 1'b0};
            st_wdata = {2{write_data_in[15:0]}};
         end
         default: ;
      endcase
   end

`ifdef MEM_MISALIGN_TRAP_EN
   // A halfword must be 2-byte aligned and a word must be 4-byte aligned.
   // Byte accesses can never be misaligned.
   always_comb begin
      misaligned = 1'b0;
      case (access_size(func3_in))
         2'd1:    misaligned = alu_result_in[0];
         2'd2:    misaligned = (alu_result_in[1:0] != 2'b00);
         default: misaligned = 1'b0;
      endcase
   end
`else
   assign misaligned = 1'b0;
`endif

   // Next-state and stall logic.
   //
   // The bus fields are only rewritten when a new access is accepted, so they
   // stay stable for the whole REQ phase.
   //
   // The error flags are cleared when the next access starts. They are only
   // visible through the DONE-gated outputs, which makes each flag a
   // one-cycle pulse.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      addr_d      = addr_q;
      we_d        = we_q;
      be_d        = be_q;
      wdata_d     = wdata_q;
      func3_d     = func3_q;
      offset_d    = offset_q;
      is_load_d   = is_load_q;
      load_data_d = load_data_q;
      bus_err_d   = bus_err_q;
      misalign_d  = misalign_q;
      stall_o     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (mem_op) begin
               stall_o    = 1'b1;
               bus_err_d  = 1'b0;
               misalign_d = 1'b0;
               wait_cnt_d = '0;
               if (misaligned) begin
                  // A trapped access never reaches the bus.
                  misalign_d  = 1'b1;
                  load_data_d = 32'd0;
                  state_d     = ST_DONE;
               end else begin
                  // A store wins when both read and write are set.
                  addr_d    = {alu_result_in[31:2], 2'b00};
                  we_d      = mem_write_in;
                  be_d      = mem_write_in ? st_be : 4'hF;
                  wdata_d   = mem_write_in ? st_wdata : 32'd0;
                  func3_d   = func3_in;
                  offset_d  = alu_result_in[1:0];
                  is_load_d = ~mem_write_in;
                  state_d   = ST_REQ;
               end
            end
         end

         ST_REQ: begin
            stall_o = 1'b1;
            if (dmem_ready) begin
               if (is_load_q) begin
                  load_data_d = extend_load(dmem_rdata, func3_q, offset_q);
               end
               state_d = ST_DONE;
            end else if (wait_cnt_q == CNT_LAST) begin
               // Timed out: abandon the access and return zero for a load.
               bus_err_d = 1'b1;
               if (is_load_q) begin
                  load_data_d = 32'd0;
               end
               state_d = ST_DONE;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset abandons any outstanding access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wait_cnt_q  <= '0;
         addr_q      <= 32'd0;
         we_q        <= 1'b0;
         be_q        <= 4'd0;
         wdata_q     <= 32'd0;
         func3_q     <= 3'd0;
         offset_q    <= 2'd0;
         is_load_q   <= 1'b0;
         load_data_q <= 32'd0;
         bus_err_q   <= 1'b0;
         misalign_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         be_q        <= be_d;
         wdata_q     <= wdata_d;
         func3_q     <= func3_d;
         offset_q    <= offset_d;
         is_load_q   <= is_load_d;
         load_data_q <= load_data_d;
         bus_err_q   <= bus_err_d;
         misalign_q  <= misalign_d;
      end
   end

   assign dmem_req      = (state_q == ST_REQ);
   assign dmem_we       = we_q;
   assign dmem_addr     = addr_q;
   assign dmem_be       = be_q;
   assign dmem_wdata    = wdata_q;
   assign load_data_out = load_data_q;
   assign bus_err_o     = (state_q == ST_DONE) & bus_err_q;

`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign_o = (state_q == ST_DONE) & misalign_q;
`else
   assign misalign_o = 1'b0;
`endif

   // A stalled cycle is a bubble, and a faulted access must not retire its
   // destination register.
   assign rf_en_out = rf_en_in & ~stall_o
                      & ~((state_q == ST_DONE) & (bus_err_q | misalign_q));

   assign wb_sel_out     = wb_sel_in;
   assign rd_out         = rd_in;
   assign alu_result_out = alu_result_in;
   assign pc_out         = pc_in;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Testbench for mem_stage_lsu.
//
// The bench has three parts:
//   - A table of directed vectors, each with hand-computed expected results.
//   - Hand-written reset sequences.
//   - Randomized operations, checked against a reference model computed
//     from the load/store rules.
module tb_mem_stage_lsu;

   localparam int WAIT_LIMIT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        rf_en_in;
   logic [1:0]  wb_sel_in;
   logic        mem_read_in;
   logic        mem_write_in;
   logic [2:0]  func3_in;
   logic [31:0] alu_result_in;
   logic [31:0] write_data_in;
   logic [4:0]  rd_in;
   logic [31:0] pc_in;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic        stall_o;
   logic        rf_en_out;
   logic [1:0]  wb_sel_out;
   logic [4:0]  rd_out;
   logic [31:0] alu_result_out;
   logic [31:0] pc_out;
   logic [31:0] load_data_out;
   logic        bus_err_o;
   logic        misalign_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_stage_lsu #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
      .clk(clk), .rst(rst),
      .rf_en_in(rf_en_in), .wb_sel_in(wb_sel_in),
      .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .func3_in(func3_in), .alu_result_in(alu_result_in),
      .write_data_in(write_data_in), .rd_in(rd_in), .pc_in(pc_in),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .stall_o(stall_o), .rf_en_out(rf_en_out), .wb_sel_out(wb_sel_out),
      .rd_out(rd_out), .alu_result_out(alu_result_out), .pc_out(pc_out),
      .load_data_out(load_data_out), .bus_err_o(bus_err_o),
      .misalign_o(misalign_o)
   );

   // delay = number of REQ cycles without ready; -1 means ready never comes.
   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          delay;
      logic        rf;
      logic [1:0]  wb_sel;
      logic [4:0]  rdi;
      logic [31:0] pc;
   } op_t;

   typedef struct packed {
      int          stall;
      int          req;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] load;
      logic [3:0]  be;
      logic        we;
      logic        err;
      logic        rf;
      logic        mis;
      logic        chk_bus;
      logic        chk_wdata;
      logic        chk_load;
   } exp_t;

   typedef struct packed {
      int          stall;
      int          req;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] load;
      logic [3:0]  be;
      logic        we;
      logic        err;
      logic        rf;
      logic        mis;
      logic        done;
      logic        unstable;
      logic        rf_leak;
      logic        pt_bad;
      logic        post_busy;
   } res_t;

   typedef struct packed {
      op_t  op;
      exp_t e;
   } vec_t;

   vec_t vecs [16];
   int   nvec = 0;

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input op_t op);
      mem_read_in   = op.rd;
      mem_write_in  = op.wr;
      func3_in      = op.f3;
      alu_result_in = op.addr;
      write_data_in = op.wdata;
      dmem_rdata    = op.rdata;
      rf_en_in      = op.rf;
      wb_sel_in     = op.wb_sel;
      rd_in         = op.rdi;
      pc_in         = op.pc;
   endtask

   task automatic drive_nop();
      mem_read_in  = 1'b0;
      mem_write_in = 1'b0;
      rf_en_in     = 1'b0;
      dmem_ready   = 1'b0;
   endtask

   function automatic vec_t mk_vec(
      input logic rd, input logic wr, input logic [2:0] f3,
      input logic [31:0] addr, input logic [31:0] wdata,
      input logic [31:0] rdata, input int delay, input logic rf,
      input int stall, input logic [31:0] eaddr, input logic [3:0] be,
      input logic [31:0] ewdata, input logic [31:0] eload,
      input logic err, input logic erf, input int idx);
      vec_t v;
      v = '0;
      v.op.rd = rd;       v.op.wr = wr;       v.op.f3 = f3;
      v.op.addr = addr;   v.op.wdata = wdata; v.op.rdata = rdata;
      v.op.delay = delay; v.op.rf = rf;
      v.op.wb_sel = 2'(idx);
      v.op.rdi = 5'(idx + 1);
      v.op.pc = 32'h1000 + 32'(idx * 4);
      v.e.stall = stall;
      v.e.req = (stall > 0) ? stall - 1 : 0;
      v.e.addr = eaddr;   v.e.be = be;        v.e.wdata = ewdata;
      v.e.we = wr;        v.e.load = eload;   v.e.err = err;
      v.e.rf = erf;       v.e.mis = 1'b0;
      v.e.chk_bus = rd | wr;
      v.e.chk_wdata = wr;
      v.e.chk_load = rd & ~wr;
      return v;
   endfunction

   // Reference model written from the load/store rules with plain arithmetic.
   function automatic exp_t model(input op_t op);
      exp_t e;
      int size, off, bits;
      logic [31:0] v, mask;
      logic mem, timeout, mis;
      e = '0;
      mem = op.rd | op.wr;
      case (op.f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         default:    size = 4;
      endcase
      mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      if (size == 2 && (op.addr % 2) != 0) mis = mem;
      if (size == 4 && (op.addr % 4) != 0) mis = mem;
`endif
      timeout = mem && !mis && (op.delay < 0 || op.delay >= WAIT_LIMIT);
      if (!mem)          begin e.stall = 0; e.req = 0; end
      else if (mis)      begin e.stall = 1; e.req = 0; end
      else if (timeout)  begin e.stall = WAIT_LIMIT + 1; e.req = WAIT_LIMIT; end
      else               begin e.stall = op.delay + 2; e.req = op.delay + 1; end
      e.addr = op.addr & 32'hFFFF_FFFC;
      e.we = op.wr;
      e.be = 4'hF;
      e.wdata = op.wdata;
      if (op.wr && size == 1) begin
         e.be = 4'(1 << (op.addr % 4));
         e.wdata = (op.wdata & 32'hFF) * 32'h0101_0101;
      end else if (op.wr && size == 2) begin
         e.be = 4'(3 << (op.addr & 2));
         e.wdata = (op.wdata & 32'hFFFF) * 32'h0001_0001;
      end
      off  = (size == 1) ? int'(op.addr % 4) : (size == 2) ? int'(op.addr & 2) : 0;
      bits = 8 * size;
      v = op.rdata >> (8 * off);
      if (bits < 32) begin
         mask = (32'd1 << bits) - 32'd1;
         v = v & mask;
         if (op.f3 < 3'd4 && v[bits-1]) v = v | ~mask;
      end
      e.load = (timeout || mis) ? 32'd0 : v;
      e.err = timeout;
      e.mis = mis;
      e.rf = op.rf & ~timeout & ~mis;
      e.chk_bus = mem & ~mis;
      e.chk_wdata = op.wr & ~mis;
      e.chk_load = op.rd & ~op.wr;
      return e;
   endfunction

   // Drives one instruction and plays the memory side, starting #1 after a
   // rising edge with the DUT idle. It records what was observed on the bus
   // and at the retire (non-stall) cycle.
   task automatic run_op(input op_t op, output res_t r);
      int cyc;
      r = '0;
      applyStimulus(op);
      dmem_ready = 1'b0;
      cyc = 0;
      while (!r.done && cyc < 64) begin
         if (dmem_req) begin
            r.req++;
            if (r.req == 1) begin
               r.addr = dmem_addr; r.be = dmem_be;
               r.wdata = dmem_wdata; r.we = dmem_we;
            end else if (dmem_addr !== r.addr || dmem_be !== r.be ||
                         dmem_wdata !== r.wdata || dmem_we !== r.we) begin
               r.unstable = 1'b1;
            end
            dmem_ready = (op.delay >= 0) && (r.req > op.delay);
         end else begin
            dmem_ready = 1'b0;
         end
         @(negedge clk);
         if (wb_sel_out !== op.wb_sel || rd_out !== op.rdi ||
             alu_result_out !== op.addr || pc_out !== op.pc) r.pt_bad = 1'b1;
         if (stall_o) begin
            r.stall++;
            if (rf_en_out) r.rf_leak = 1'b1;
         end else begin
            r.done = 1'b1;
            r.load = load_data_out;
            r.err  = bus_err_o;
            r.rf   = rf_en_out;
            r.mis  = misalign_o;
         end
         @(posedge clk); #1;
         cyc++;
      end
      drive_nop();
      @(negedge clk);
      r.post_busy = stall_o | dmem_req | bus_err_o | misalign_o;
      @(posedge clk); #1;
   endtask

   task automatic check_op(input string tag, input exp_t e, input res_t r);
      checkOutput({tag, ".done"},     32'(r.done), 32'd1);
      checkOutput({tag, ".stall"},    32'(r.stall), 32'(e.stall));
      checkOutput({tag, ".req"},      32'(r.req), 32'(e.req));
      checkOutput({tag, ".rf_out"},   32'(r.rf), 32'(e.rf));
      checkOutput({tag, ".bus_err"},  32'(r.err), 32'(e.err));
      checkOutput({tag, ".misalign"}, 32'(r.mis), 32'(e.mis));
      checkOutput({tag, ".rf_leak"},  32'(r.rf_leak), 32'd0);
      checkOutput({tag, ".passthru"}, 32'(r.pt_bad), 32'd0);
      checkOutput({tag, ".idle_after"}, 32'(r.post_busy), 32'd0);
      if (e.chk_bus) begin
         checkOutput({tag, ".addr"},   r.addr, e.addr);
         checkOutput({tag, ".be"},     32'(r.be), 32'(e.be));
         checkOutput({tag, ".we"},     32'(r.we), 32'(e.we));
         checkOutput({tag, ".stable"}, 32'(r.unstable), 32'd0);
      end
      if (e.chk_wdata) checkOutput({tag, ".wdata"}, r.wdata, e.wdata);
      if (e.chk_load)  checkOutput({tag, ".load"}, r.load, e.load);
   endtask

   initial begin
      op_t  op;
      res_t r;
      exp_t e;

      // Directed vectors: rd wr f3 addr wdata rdata delay rf | stall addr be wdata load err rf
      vecs[nvec] = mk_vec(0,0,3'd0,32'h1234,0,0,0,1, 0,0,4'h0,0,0,0,1, nvec); nvec++;
      vecs[nvec] = mk_vec(0,1,3'd0,32'h103,32'hA5,0,0,0, 2,32'h100,4'b1000,32'hA5A5A5A5,0,0,0, nvec); nvec++;
      vecs[nvec] = mk_vec(1,0,3'd0,32'h102,0,32'h0080_0000,0,1, 2,32'h100,4'hF,0,32'hFFFF_FF80,0,1, nvec); nvec++;
      vecs[nvec] = mk_vec(1,0,3'd4,32'h102,0,32'h0080_0000,0,1, 2,32'h100,4'hF,0,32'h0000_0080,0,1, nvec); nvec++;
      vecs[nvec] = mk_vec(1,0,3'd2,32'h200,0,32'hDEAD_BEEF,5,1, 7,32'h200,4'hF,0,32'hDEAD_BEEF,0,1, nvec); nvec++;
      vecs[nvec] = mk_vec(1,0,3'd2,32'h300,0,32'h1111_1111,-1,1, 17,32'h300,4'hF,0,32'h0,1,0, nvec); nvec++;
      vecs[nvec] = mk_vec(0,1,3'd1,32'h102,32'h1234_BEEF,0,1,0, 3,32'h100,4'b1100,32'hBEEF_BEEF,0,0,0, nvec); nvec++;
      vecs[nvec] = mk_vec(1,0,3'd1,32'h106,0,32'h8001_7FFF,0,1, 2,32'h104,4'hF,0,32'hFFFF_8001,0,1, nvec); nvec++;
      vecs[nvec] = mk_vec(1,0,3'd5,32'h106,0,32'h8001_7FFF,0,1, 2,32'h104,4'hF,0,32'h0000_8001,0,1, nvec); nvec++;
      vecs[nvec] = mk_vec(1,0,3'd3,32'h10,0,32'hCAFE_BABE,0,1, 2,32'h10,4'hF,0,32'hCAFE_BABE,0,1, nvec); nvec++;
      vecs[nvec] = mk_vec(1,1,3'd2,32'h40,32'h55AA_55AA,0,0,0, 2,32'h40,4'hF,32'h55AA_55AA,0,0,0, nvec); nvec++;
      vecs[nvec] = mk_vec(1,0,3'd2,32'h500,0,32'h0BAD_F00D,15,1, 17,32'h500,4'hF,0,32'h0BAD_F00D,0,1, nvec); nvec++;
      vecs[nvec] = mk_vec(0,1,3'd2,32'h600,32'h0102_0304,0,-1,0, 17,32'h600,4'hF,32'h0102_0304,0,1,0, nvec); nvec++;
`ifndef MEM_MISALIGN_TRAP_EN
      vecs[nvec] = mk_vec(1,0,3'd2,32'h203,0,32'h1122_3344,2,1, 4,32'h200,4'hF,0,32'h1122_3344,0,1, nvec); nvec++;
      vecs[nvec] = mk_vec(1,0,3'd1,32'h101,0,32'h0000_FF80,0,1, 2,32'h100,4'hF,0,32'hFFFF_FF80,0,1, nvec); nvec++;
`endif

      // Reset state, with the pass-through outputs following the inputs.
      rst = 1'b1;
      drive_nop();
      func3_in = 3'd0; alu_result_in = 32'h0000_0ABC; write_data_in = 32'd0;
      wb_sel_in = 2'd2; rd_in = 5'd7; pc_in = 32'h0000_0040; dmem_rdata = 32'd0;
      @(negedge clk);
      checkOutput("reset.req",      32'(dmem_req), 32'd0);
      checkOutput("reset.we",       32'(dmem_we), 32'd0);
      checkOutput("reset.addr",     dmem_addr, 32'd0);
      checkOutput("reset.be",       32'(dmem_be), 32'd0);
      checkOutput("reset.wdata",    dmem_wdata, 32'd0);
      checkOutput("reset.load",     load_data_out, 32'd0);
      checkOutput("reset.bus_err",  32'(bus_err_o), 32'd0);
      checkOutput("reset.misalign", 32'(misalign_o), 32'd0);
      checkOutput("reset.stall",    32'(stall_o), 32'd0);
      checkOutput("reset.alu_pt",   alu_result_out, 32'h0000_0ABC);
      checkOutput("reset.rd_pt",    32'(rd_out), 32'd7);
      checkOutput("reset.pc_pt",    pc_out, 32'h0000_0040);
      checkOutput("reset.wbsel_pt", 32'(wb_sel_out), 32'd2);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < nvec; i++) begin
         run_op(vecs[i].op, r);
         check_op($sformatf("vec%0d", i), vecs[i].e, r);
      end

      // Reset in the middle of a REQ phase abandons the access immediately.
      op = '0;
      op.rd = 1'b1; op.f3 = 3'd2; op.addr = 32'h400; op.rdata = 32'h7777_7777;
      op.rf = 1'b1; op.delay = -1;
      applyStimulus(op);
      dmem_ready = 1'b0;
      @(posedge clk); #1;
      checkOutput("rstmid.req_before", 32'(dmem_req), 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checkOutput("rstmid.req",   32'(dmem_req), 32'd0);
      checkOutput("rstmid.addr",  dmem_addr, 32'd0);
      checkOutput("rstmid.be",    32'(dmem_be), 32'd0);
      checkOutput("rstmid.we",    32'(dmem_we), 32'd0);
      checkOutput("rstmid.load",  load_data_out, 32'd0);
      checkOutput("rstmid.alu_pt", alu_result_out, 32'h400);
      drive_nop();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("rstmid.idle_stall", 32'(stall_o), 32'd0);
      checkOutput("rstmid.idle_req",   32'(dmem_req), 32'd0);
      @(posedge clk); #1;

`ifdef MEM_MISALIGN_TRAP_EN
      // A trapped halfword load must not reach the bus.
      op = '0;
      op.rd = 1'b1; op.f3 = 3'd1; op.addr = 32'h101; op.rdata = 32'hFFFF_FFFF;
      op.rf = 1'b1; op.delay = 0;
      run_op(op, r);
      checkOutput("trap.stall", 32'(r.stall), 32'd1);
      checkOutput("trap.req",   32'(r.req), 32'd0);
      checkOutput("trap.mis",   32'(r.mis), 32'd1);
      checkOutput("trap.load",  r.load, 32'd0);
      checkOutput("trap.rf",    32'(r.rf), 32'd0);
`endif

      // Randomized operations checked against the reference model.
      for (int i = 0; i < 60; i++) begin
         int kind, d;
         op = '0;
         kind = int'($urandom_range(0, 3));
         op.rd = (kind == 1) || (kind == 3);
         op.wr = (kind == 2) || (kind == 3);
         op.f3 = 3'($urandom_range(0, 7));
         op.addr = $urandom;
         op.wdata = $urandom;
         op.rdata = $urandom;
         d = int'($urandom_range(0, 19));
         op.delay = (d < 15) ? (d % 5) : (d == 15) ? -1 : (d == 16) ? 15 :
                    (d == 17) ? 16 : 0;
         op.rf = 1'($urandom_range(0, 1));
         op.wb_sel = 2'($urandom_range(0, 3));
         op.rdi = 5'($urandom_range(0, 31));
         op.pc = $urandom;
         e = model(op);
         run_op(op, r);
         check_op($sformatf("rand%0d", i), e, r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
